// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and ALU encodings plus instruction field positions
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOVI = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 6;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational split of the instruction register into fields and class flags
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  op,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [7:0]  imm,
  output logic        is_alu,
  output logic        writes_reg,
  output logic        illegal
);

  logic unused_ir11;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs1 = ir[RS1_MSB:RS1_LSB];
  assign rs2 = ir[RS2_MSB:RS2_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];
  assign unused_ir11 = ir[11];

  always_comb begin
    is_alu     = 1'b0;
    writes_reg = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        is_alu     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_MOVI: writes_reg = 1'b1;
      OP_NOP, OP_JMP, OP_JZ, OP_HALT: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/writeback sequencer driving register file and ALU
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8,
  parameter int PC_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [PC_BITS-1:0]   imem_addr,
  output logic                 imem_rd_en,
  input  logic [15:0]          imem_data,
  output logic [ADDR_BITS-1:0] rd0_addr,
  output logic [ADDR_BITS-1:0] rd1_addr,
  output logic                 rd0_enable,
  output logic                 rd1_enable,
  output logic [1:0]           alu_op,
  input  logic [DATA_BITS-1:0] alu_result,
  input  logic                 alu_zero,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_enable,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 halted,
  output logic                 illegal_op
);

  state_t               state, state_next;
  logic [PC_BITS-1:0]   pc;
  logic [15:0]          ir;
  logic [DATA_BITS-1:0] result;
  logic                 zflag;

  logic [3:0] dec_op;
  logic [2:0] dec_rd, dec_rs1, dec_rs2;
  logic [7:0] dec_imm;
  logic       dec_is_alu, dec_writes_reg, dec_illegal;

  instr_decoder u_decoder (
    .ir         (ir),
    .op         (dec_op),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .imm        (dec_imm),
    .is_alu     (dec_is_alu),
    .writes_reg (dec_writes_reg),
    .illegal    (dec_illegal)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers follow the state the FSM is leaving on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      ir     <= '0;
      result <= '0;
      zflag  <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ir <= imem_data;
          pc <= pc + PC_BITS'(1);
        end
        S_EXECUTE: begin
          if (dec_is_alu) begin
            result <= alu_result;
            zflag  <= alu_zero;
          end else if (dec_op == OP_MOVI) begin
            result <= DATA_BITS'(dec_imm);
          end else if (dec_op == OP_JMP || (dec_op == OP_JZ && zflag)) begin
            pc <= PC_BITS'(dec_imm);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    imem_rd_en = 1'b0;
    rd0_addr   = '0;
    rd1_addr   = '0;
    rd0_enable = 1'b0;
    rd1_enable = 1'b0;
    alu_op     = ALU_PASS;
    wr_addr    = '0;
    wr_enable  = 1'b0;
    wr_data    = '0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        imem_rd_en = reset;
        state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        state_next = S_FETCH;
        if (dec_is_alu) begin
          rd0_addr   = ADDR_BITS'(dec_rs1);
          rd1_addr   = ADDR_BITS'(dec_rs2);
          rd0_enable = 1'b1;
          rd1_enable = 1'b1;
          alu_op     = (dec_op == OP_SUB) ? ALU_SUB : ALU_ADD;
        end
        if (dec_writes_reg) state_next = S_WRITEBACK;
        if (dec_op == OP_HALT) state_next = S_HALTED;
        illegal_op = dec_illegal;
      end
      S_WRITEBACK: begin
        wr_enable  = 1'b1;
        wr_addr    = ADDR_BITS'(dec_rd);
        wr_data    = result;
        state_next = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench with an instruction-level reference model
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic [2:0]  rd0_addr, rd1_addr, wr_addr;
  logic        rd0_enable, rd1_enable, wr_enable;
  logic [1:0]  alu_op;
  logic [7:0]  alu_result, wr_data;
  logic        alu_zero, halted, illegal_op;

  logic [15:0] mem [256];
  logic [15:0] imem_q = 16'h0000;
  logic [7:0]  rf [8] = '{default: 8'h00};
  logic [7:0]  mreg [8];
  logic [7:0]  m_pc;
  logic        m_z;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_data  (imem_data),
    .rd0_addr   (rd0_addr),
    .rd1_addr   (rd1_addr),
    .rd0_enable (rd0_enable),
    .rd1_enable (rd1_enable),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wr_addr    (wr_addr),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  assign imem_data = imem_q;

  always @(posedge clk) begin
    if (imem_rd_en) imem_q <= mem[imem_addr];
    if (wr_enable) rf[wr_addr] <= wr_data;
  end

  always_comb begin
    case (alu_op)
      2'b01:   alu_result = rf[rd0_addr] + rf[rd1_addr];
      2'b10:   alu_result = rf[rd0_addr] - rf[rd1_addr];
      default: alu_result = rf[rd0_addr];
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    m_pc = 8'h00;
    m_z = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Runs one instruction from its FETCH cycle, checking every cycle against the ISA-level model.
  task automatic exec_one(input string tag);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm, val;
    logic        wr, alu, ill;
    logic [1:0]  exp_op;
    n_cmp++;
    if (imem_rd_en !== 1'b1 || imem_addr !== m_pc || wr_enable !== 1'b0 || illegal_op !== 1'b0) begin
      n_err++;
      $display("FAIL %s fetch: rd_en=%b addr=%h wr_en=%b ill=%b, required rd_en=1 addr=%h wr_en=0 ill=0",
               tag, imem_rd_en, imem_addr, wr_enable, illegal_op, m_pc);
    end
    ins = mem[m_pc];
    op  = ins[15:12];
    rd  = ins[10:8];
    rs1 = ins[6:4];
    rs2 = ins[2:0];
    imm = ins[7:0];
    m_pc = m_pc + 8'd1;
    wr  = (op == 4'h1 || op == 4'h2 || op == 4'h3);
    alu = (op == 4'h2 || op == 4'h3);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hF: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    exp_op = (op == 4'h3) ? 2'b10 : (op == 4'h2) ? 2'b01 : 2'b00;
    tick();
    n_cmp++;
    if (imem_rd_en !== 1'b0 || wr_enable !== 1'b0 || rd0_enable !== 1'b0 || illegal_op !== 1'b0) begin
      n_err++;
      $display("FAIL %s decode: rd_en=%b wr_en=%b rd0_en=%b ill=%b, required all 0",
               tag, imem_rd_en, wr_enable, rd0_enable, illegal_op);
    end
    tick();
    n_cmp++;
    if (illegal_op !== ill || rd0_enable !== alu || rd1_enable !== alu || alu_op !== exp_op ||
        (alu && (rd0_addr !== rs1 || rd1_addr !== rs2))) begin
      n_err++;
      $display("FAIL %s execute: ill=%b en=%b%b op=%b ra=%0d rb=%0d, required ill=%b en=%b op=%b ra=%0d rb=%0d",
               tag, illegal_op, rd0_enable, rd1_enable, alu_op, rd0_addr, rd1_addr,
               ill, alu, exp_op, rs1, rs2);
    end
    val = 8'h00;
    case (op)
      4'h1: val = imm;
      4'h2: begin val = mreg[rs1] + mreg[rs2]; m_z = (val == 8'h00); end
      4'h3: begin val = mreg[rs1] - mreg[rs2]; m_z = (val == 8'h00); end
      4'h5: m_pc = imm;
      4'h6: if (m_z) m_pc = imm;
      default: ;
    endcase
    if (wr) begin
      tick();
      n_cmp++;
      if (wr_enable !== 1'b1 || wr_addr !== rd || wr_data !== val) begin
        n_err++;
        $display("FAIL %s writeback: wr_en=%b addr=%0d data=%h, required wr_en=1 addr=%0d data=%h",
                 tag, wr_enable, wr_addr, wr_data, rd, val);
      end
      mreg[rd] = val;
    end
    tick();
    if (op == 4'hF) begin
      n_cmp++;
      if (halted !== 1'b1 || imem_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s halt: halted=%b rd_en=%b, required halted=1 rd_en=0", tag, halted, imem_rd_en);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (imem_rd_en !== 1'b0 || imem_addr !== 8'h00 || wr_enable !== 1'b0 || halted !== 1'b0 ||
        illegal_op !== 1'b0 || rd0_enable !== 1'b0 || alu_op !== 2'b00 || wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: rd_en=%b addr=%h wr_en=%b halted=%b ill=%b, required all 0",
               imem_rd_en, imem_addr, wr_enable, halted, illegal_op);
    end
    reset = 1'b1;
    m_pc = 8'h00;
    m_z = 1'b0;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release: rd_en=%b addr=%h, required rd_en=1 addr=00", imem_rd_en, imem_addr);
    end
  endtask

  task automatic test_movi();
    exec_one("movi_r3");
    exec_one("movi_next");
  endtask

  task automatic test_add_jz();
    clear_mem();
    mem[0] = 16'h1180;
    mem[1] = 16'h1280;
    mem[2] = 16'h2412;
    mem[3] = 16'h6020;
    do_reset();
    for (int i = 0; i < 5; i++) exec_one("add_jz");
  endtask

  task automatic test_sub_jz();
    clear_mem();
    mem[0] = 16'h1107;
    mem[1] = 16'h3511;
    mem[2] = 16'h1209;
    mem[3] = 16'h3621;
    mem[4] = 16'h6040;
    do_reset();
    for (int i = 0; i < 6; i++) exec_one("sub_jz");
  endtask

  task automatic test_wrap_illegal();
    clear_mem();
    mem[0] = 16'h50FF;
    do_reset();
    for (int i = 0; i < 3; i++) exec_one("pc_wrap");
    clear_mem();
    mem[0] = 16'h7123;
    do_reset();
    for (int i = 0; i < 2; i++) exec_one("illegal");
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 16'hF000;
    do_reset();
    exec_one("halt");
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (halted !== 1'b1 || imem_rd_en !== 1'b0 || wr_enable !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: halted=%b rd_en=%b wr_en=%b, required 1 0 0",
                 i, halted, imem_rd_en, wr_enable);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_reset: halted=%b, required 0", halted);
    end
    @(negedge clk);
    reset = 1'b1;
    m_pc = 8'h00;
    m_z = 1'b0;
    #1;
    n_cmp++;
    if (imem_addr !== 8'h00 || imem_rd_en !== 1'b1 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_restart: addr=%h rd_en=%b halted=%b, required 00 1 0", imem_addr, imem_rd_en, halted);
    end
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 16'h3211;
    mem[1] = 16'h1333;
    do_reset();
    exec_one("async_sub");
    tick();
    tick();
    tick();
    n_cmp++;
    if (wr_enable !== 1'b1) begin
      n_err++;
      $display("FAIL async_wb_reached: wr_en=%b, required 1", wr_enable);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (wr_enable !== 1'b0 || wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL async_abort: wr_en=%b data=%h, required wr_en=0 data=00", wr_enable, wr_data);
    end
    m_pc = 8'h00;
    m_z = 1'b0;
    mem[0] = 16'h6010;
    mem[1] = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    #1;
    exec_one("async_jz");
    exec_one("async_after");
  endtask

  task automatic test_random();
    logic [3:0]  ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h4, 4'h7, 4'h9, 4'hE};
    logic [15:0] r;
    for (int i = 0; i < 256; i++) begin
      r = 16'($urandom());
      r[15:12] = ops[$urandom_range(0, 9)];
      mem[i] = r;
    end
    do_reset();
    for (int i = 0; i < 80; i++) exec_one("random");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    clear_mem();
    mem[0] = 16'h135A;
    m_pc = 8'h00;
    m_z = 1'b0;
    test_reset();
    test_movi();
    test_add_jz();
    test_sub_jz();
    test_wrap_illegal();
    test_halt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, required completion before 300000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer that sits directly upstream of the 8-entry register file.
- Fetches 16-bit instructions from a synchronous instruction memory and drives the register file's read ports, the external ALU's opcode and the register file's write port.
- Holds the PC, the instruction register and the zero flag.

Parameters:
- ADDR_BITS, 3, register address width. The instruction encoding requires 3.
- DATA_BITS, 8, register and ALU data width. The encoding requires 8.
- PC_BITS, 8, program counter and instruction memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- imem_addr  output  PC_BITS  instruction memory address; always equals PC.
- imem_rd_en  output  1  instruction memory read strobe; data valid one cycle later.
- imem_data  input  16  instruction word.
- rd0_addr, rd1_addr  output  ADDR_BITS each  register file read addresses.
- rd0_enable, rd1_enable  output  1 each  register file read enables.
- alu_op  output  2  ALU operation: 00 = pass, 01 = add, 10 = sub. The ALU takes its operands from rd0_data/rd1_data.
- alu_result  input  DATA_BITS  combinational ALU result.
- alu_zero  input  1  alu_result == 0.
- wr_addr  output  ADDR_BITS  register file write address.
- wr_enable  output  1  register file write enable, one-cycle pulse.
- wr_data  output  DATA_BITS  register file write data.
- halted  output  1  high in the HALTED state.
- illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Encoding: op = ir[15:12], rd = ir[10:8], rs1 = ir[6:4], rs2 = ir[2:0], imm = ir[7:0]; ir[11] is ignored.
- Opcodes: 0 NOP, 1 MOVI (rd <= imm), 2 ADD (rd <= rs1 + rs2), 3 SUB (rd <= rs1 - rs2), 5 JMP (pc <= imm), 6 JZ (pc <= imm if Z), F HALT. All others are illegal.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- FETCH:
  - imem_rd_en = 1.
  - Next state DECODE.
- DECODE:
  - ir <= imem_data; pc <= pc + 1 (modulo 2^PC_BITS, so 0xFF wraps to 0x00).
  - Next state EXECUTE.
- EXECUTE:
  - ADD/SUB: rd0_addr = rs1, rd1_addr = rs2, both enables = 1, alu_op = add/sub. Latch result <= alu_result and Z <= alu_zero. Next state WRITEBACK.
  - MOVI: result <= imm. Next state WRITEBACK. Z is unchanged.
  - JMP: pc <= imm. Next state FETCH.
  - JZ: pc <= imm if Z = 1. Next state FETCH.
  - NOP: next state FETCH.
  - Illegal opcode: illegal_op = 1 for this cycle; treated as NOP.
  - HALT: next state HALTED.
- WRITEBACK:
  - wr_enable = 1, wr_addr = rd, wr_data = result.
  - Next state FETCH.
- HALTED: absorbing. No strobes are asserted; only reset exits.
- Latency:
  - ADD/SUB/MOVI: 4 cycles each.
  - NOP/JMP/JZ/illegal: 3 cycles each.
  - HALT: 3 cycles to reach HALTED.
- Outside the cycles listed above, every enable and strobe is 0 and addresses are 0.
- Reset (asynchronous, any state, including mid-instruction): state = FETCH, pc = 0, ir = 0, result = 0, Z = 0. All outputs are 0, except imem_rd_en, which is 1 once reset is released (FETCH).
- A write in progress when reset is asserted is aborted; wr_enable drops immediately.
- rd == rs1 or rd == rs2 is legal. Reads occur in EXECUTE and the write occurs in WRITEBACK, so no hazard exists.
- JZ tests the Z value left by the most recent ADD/SUB. Z = 0 after reset.
- Arithmetic wraps modulo 2^DATA_BITS; there is no carry output.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum;
  - the state enum;
  - the alu_op enum;
  - the instruction field bit positions.
- Sub-module instr_decoder: combinational ir -> {op, rd, rs1, rs2, imm, is_alu, writes_reg, illegal}.

Test Plan:
- Reset release, imem holds MOVI r3,0x5A (0x135A) at addr 0 -> 4th cycle: wr_enable=1, wr_addr=3, wr_data=0x5A; imem_addr=1 in the next FETCH.
- Program MOVI r1,0x80; MOVI r2,0x80; ADD r4,r1,r2 (0x2412); ALU model is combinational -> wr_data=0x00 to r4, Z=1; following JZ 0x20 (0x6020) -> next imem_addr=0x20.
- SUB r5,r1,r1 after MOVI r1,0x07, then SUB r6,r2,r1 with r2=0x09 -> Z=0 after second SUB; JZ 0x40 not taken, next imem_addr = JZ address + 1.
- PC at 0xFF holding NOP (0x0000) -> next FETCH imem_addr=0x00; opcode 0x7 at any address -> illegal_op pulses exactly 1 cycle, no wr_enable.
- HALT (0xF000) -> halted=1 three cycles after FETCH and stays high for 20 cycles with imem_rd_en=0; reset low then high -> halted=0, imem_addr=0.
- Reset asserted asynchronously mid-WRITEBACK (between clock edges) -> wr_enable drops immediately; after release, execution restarts at addr 0 with Z=0.
